// File: rtl/seq_divider.sv
// seq_divider: sequential restoring divider, one quotient bit per SHIFT/TRIAL pair.
// Optional two's-complement mode: define SEQ_DIVIDER_SIGNED_EN (adds FIX state).
module seq_divider #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Run,
  input  logic [WIDTH-1:0] Dividend,
  input  logic [WIDTH-1:0] Divisor,
  output logic [WIDTH-1:0] Quotient,
  output logic [WIDTH-1:0] Remainder,
  output logic             Busy,
  output logic             Done,
  output logic             DivZero
);

  localparam int unsigned CW = $clog2(WIDTH);

`ifdef SEQ_DIVIDER_SIGNED_EN
  typedef enum logic [2:0] {S_IDLE, S_SHIFT, S_TRIAL, S_HOLD, S_FIX} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_SHIFT, S_TRIAL, S_HOLD} state_t;
`endif

  state_t           state_q, state_d;
  logic [WIDTH:0]   a_q, a_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dz_q, dz_d;
  logic [WIDTH-1:0] dvd_mag, dvs_mag;
  logic [WIDTH:0]   diff;
  logic             diff_ok;

  // A is one bit wider than M, so the sign of A-M is simply the top bit.
  assign diff    = a_q - {1'b0, m_q};
  assign diff_ok = ~diff[WIDTH];

`ifdef SEQ_DIVIDER_SIGNED_EN
  logic qneg_q, qneg_d;
  logic rneg_q, rneg_d;

  // Magnitudes of the operands; the most-negative value maps to 2^(WIDTH-1).
  assign dvd_mag = Dividend[WIDTH-1] ? -Dividend : Dividend;
  assign dvs_mag = Divisor[WIDTH-1]  ? -Divisor  : Divisor;

  // Latched sign flags for the FIX correction step.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      qneg_q <= 1'b0;
      rneg_q <= 1'b0;
    end else begin
      qneg_q <= qneg_d;
      rneg_q <= rneg_d;
    end
  end
`else
  assign dvd_mag = Dividend;
  assign dvs_mag = Divisor;
`endif

  // State register.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Datapath and result registers.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      a_q   <= '0;
      q_q   <= '0;
      m_q   <= '0;
      cnt_q <= '0;
      quo_q <= '0;
      rem_q <= '0;
      dz_q  <= 1'b0;
    end else begin
      a_q   <= a_d;
      q_q   <= q_d;
      m_q   <= m_d;
      cnt_q <= cnt_d;
      quo_q <= quo_d;
      rem_q <= rem_d;
      dz_q  <= dz_d;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    q_d     = q_q;
    m_d     = m_q;
    cnt_d   = cnt_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dz_d    = dz_q;
`ifdef SEQ_DIVIDER_SIGNED_EN
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (Run) begin
          if (Divisor == '0) begin
            quo_d   = '1;
            rem_d   = Dividend;
            dz_d    = 1'b1;
            state_d = S_HOLD;
          end else begin
            q_d     = dvd_mag;
            m_d     = dvs_mag;
            a_d     = '0;
            cnt_d   = '0;
`ifdef SEQ_DIVIDER_SIGNED_EN
            qneg_d  = Dividend[WIDTH-1] ^ Divisor[WIDTH-1];
            rneg_d  = Dividend[WIDTH-1];
`endif
            state_d = S_SHIFT;
          end
        end
      end
      S_SHIFT: begin
        a_d     = {a_q[WIDTH-1:0], q_q[WIDTH-1]};
        q_d     = {q_q[WIDTH-2:0], 1'b0};
        state_d = S_TRIAL;
      end
      S_TRIAL: begin
        q_d = {q_q[WIDTH-1:1], diff_ok};
        if (diff_ok) a_d = diff;
        if (cnt_q == CW'(WIDTH - 1)) begin
`ifdef SEQ_DIVIDER_SIGNED_EN
          state_d = S_FIX;
`else
          quo_d   = {q_q[WIDTH-1:1], diff_ok};
          rem_d   = diff_ok ? diff[WIDTH-1:0] : a_q[WIDTH-1:0];
          state_d = S_HOLD;
`endif
        end else begin
          cnt_d   = cnt_q + CW'(1);
          state_d = S_SHIFT;
        end
      end
`ifdef SEQ_DIVIDER_SIGNED_EN
      S_FIX: begin
        quo_d   = qneg_q ? -q_q : q_q;
        rem_d   = rneg_q ? -a_q[WIDTH-1:0] : a_q[WIDTH-1:0];
        state_d = S_HOLD;
      end
`endif
      S_HOLD: begin
        if (!Run) begin
          dz_d    = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign Quotient  = quo_q;
  assign Remainder = rem_q;
  assign DivZero   = dz_q;
  assign Done      = (state_q == S_HOLD);
`ifdef SEQ_DIVIDER_SIGNED_EN
  assign Busy      = (state_q == S_SHIFT) || (state_q == S_TRIAL) || (state_q == S_FIX);
`else
  assign Busy      = (state_q == S_SHIFT) || (state_q == S_TRIAL);
`endif

endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: vector table plus hand sequences, scoreboard of expected results.
module tb_seq_divider;

`ifdef SEQ_DIVIDER_SIGNED_EN
  localparam int unsigned LAT = 18;
`else
  localparam int unsigned LAT = 17;
`endif

  logic       Clk = 1'b0;
  logic       Reset;
  logic       Run;
  logic [7:0] Dividend, Divisor;
  logic [7:0] Quotient, Remainder;
  logic       Busy, Done, DivZero;

  seq_divider #(.WIDTH(8)) dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .Run      (Run),
    .Dividend (Dividend),
    .Divisor  (Divisor),
    .Quotient (Quotient),
    .Remainder(Remainder),
    .Busy     (Busy),
    .Done     (Done),
    .DivZero  (DivZero)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [7:0]  q;
    logic [7:0]  r;
    logic        dz;
    int unsigned lat;
  } vec_t;

  vec_t        vecs[$];
  vec_t        sb[$];
  int unsigned n_total = 0;
  int unsigned n_pass  = 0;
  logic [7:0]  last_q = '0;
  logic [7:0]  last_r = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  function automatic vec_t mk(input logic [7:0] a, input logic [7:0] b,
                              input logic [7:0] q, input logic [7:0] r, input logic dz);
    vec_t v;
    v.a = a; v.b = b; v.q = q; v.r = r; v.dz = dz;
    v.lat = dz ? 1 : LAT;
    return v;
  endfunction

  // Start an operation; latency counts the start edge as edge 1.
  task automatic start_op(input vec_t v, input bit hold_run);
    vec_t        e;
    int unsigned lat;
    Dividend = v.a;
    Divisor  = v.b;
    Run      = 1'b1;
    sb.push_back(v);
    @(posedge Clk); #1;
    lat = 1;
    if (!hold_run) Run = 1'b0;
    Dividend = ~v.a;
    Divisor  = v.b + 8'd3;
    chk("busy_after_start", 32'(Busy), v.dz ? 32'd0 : 32'd1);
    while (!Done && lat < 40) begin
      if (lat == 3) chk("result_held_midop", 32'(Quotient), 32'(last_q));
      @(posedge Clk); #1;
      lat++;
    end
    e = sb.pop_front();
    chk("done_seen",  32'(Done),      32'd1);
    chk("latency",    lat,            e.lat);
    chk("quotient",   32'(Quotient),  32'(e.q));
    chk("remainder",  32'(Remainder), 32'(e.r));
    chk("divzero",    32'(DivZero),   32'(e.dz));
    chk("busy_in_hold", 32'(Busy),    32'd0);
    last_q = e.q;
    last_r = e.r;
  endtask

  task automatic finish_op(input bit hold_run);
    if (hold_run) begin
      repeat (3) begin
        @(posedge Clk); #1;
        chk("hold_with_run", 32'(Done), 32'd1);
      end
      chk("hold_q_stable", 32'(Quotient), 32'(last_q));
      Run = 1'b0;
    end
    @(posedge Clk); #1;
    chk("done_clear",    32'(Done),      32'd0);
    chk("divzero_clear", 32'(DivZero),   32'd0);
    chk("q_kept_idle",   32'(Quotient),  32'(last_q));
    chk("r_kept_idle",   32'(Remainder), 32'(last_r));
  endtask

  initial begin
`ifdef SEQ_DIVIDER_SIGNED_EN
    vecs.push_back(mk(8'h9C, 8'h07, 8'hF2, 8'hFE, 1'b0));  // -100 / 7
    vecs.push_back(mk(8'h80, 8'hFF, 8'h80, 8'h00, 1'b0));  // -128 / -1
    vecs.push_back(mk(8'h64, 8'hF9, 8'hF2, 8'h02, 1'b0));  // 100 / -7
    vecs.push_back(mk(8'hF9, 8'h02, 8'hFD, 8'hFF, 1'b0));  // -7 / 2
    vecs.push_back(mk(8'h81, 8'h80, 8'h00, 8'h81, 1'b0));  // -127 / -128
    vecs.push_back(mk(8'h00, 8'h05, 8'h00, 8'h00, 1'b0));
    vecs.push_back(mk(8'h80, 8'h00, 8'hFF, 8'h80, 1'b1));
    vecs.push_back(mk(8'h2A, 8'h00, 8'hFF, 8'h2A, 1'b1));
`else
    vecs.push_back(mk(8'd200, 8'd7,   8'h1C, 8'h04, 1'b0));
    vecs.push_back(mk(8'd0,   8'd13,  8'h00, 8'h00, 1'b0));
    vecs.push_back(mk(8'hFF,  8'hFF,  8'h01, 8'h00, 1'b0));
    vecs.push_back(mk(8'hFF,  8'd16,  8'h0F, 8'h0F, 1'b0));
    vecs.push_back(mk(8'd128, 8'd3,   8'h2A, 8'h02, 1'b0));
    vecs.push_back(mk(8'd254, 8'hFF,  8'h00, 8'hFE, 1'b0));
    vecs.push_back(mk(8'd100, 8'd1,   8'h64, 8'h00, 1'b0));
    vecs.push_back(mk(8'h2A,  8'd0,   8'hFF, 8'h2A, 1'b1));
`endif

    Reset = 1'b0; Run = 1'b0; Dividend = '0; Divisor = '0;
    repeat (3) @(posedge Clk);
    #1;
    Reset = 1'b1;
    repeat (5) @(posedge Clk);
    #1;
    chk("rst_q",    32'(Quotient),  32'd0);
    chk("rst_r",    32'(Remainder), 32'd0);
    chk("rst_done", 32'(Done),      32'd0);
    chk("rst_busy", 32'(Busy),      32'd0);
    chk("rst_dz",   32'(DivZero),   32'd0);

    for (int i = 0; i < vecs.size(); i++) begin
      start_op(vecs[i], 1'b0);
      finish_op(1'b0);
    end

    // Run held high across Done, then a below-divisor operation.
    start_op(mk(8'hFF, 8'd1, 8'hFF, 8'h00, 1'b0), 1'b1);
    finish_op(1'b1);
    start_op(mk(8'd5, 8'd9, 8'h00, 8'h05, 1'b0), 1'b0);
    finish_op(1'b0);

    // Asynchronous reset in the middle of an operation.
    Dividend = 8'd200; Divisor = 8'd7; Run = 1'b1;
    @(posedge Clk); #1;
    Run = 1'b0;
    repeat (5) @(posedge Clk);
    #3;
    Reset = 1'b0;
    #1;
    chk("midrst_q",    32'(Quotient),  32'd0);
    chk("midrst_r",    32'(Remainder), 32'd0);
    chk("midrst_busy", 32'(Busy),      32'd0);
    chk("midrst_done", 32'(Done),      32'd0);
    @(posedge Clk); #1;
    Reset  = 1'b1;
    last_q = '0;
    last_r = '0;
    start_op(mk(8'd100, 8'd10, 8'h0A, 8'h00, 1'b0), 1'b0);
    finish_op(1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
